// File: rtl/attn_seq_pkg.sv
// attn_seq_pkg: shared types and constants for the attention sequencer
// No ports. Provides the FSM and phase enums, the job descriptor struct,
// the operand-select encodings and a wrapping multiply helper.
package attn_seq_pkg;
    localparam int JOB_ADDR_W = 12;
    localparam int JOB_DIM_W  = 16;

    localparam logic SEL_A_INPUT   = 1'b0;
    localparam logic SEL_A_RESULT  = 1'b1;
    localparam logic SEL_B_WEIGHT  = 1'b0;
    localparam logic SEL_B_SCRATCH = 1'b1;

    typedef enum logic [2:0] {IDLE, PREP, ISSUE, WAIT, NEXT, DONE} state_t;
    typedef enum logic [2:0] {PH_Q, PH_K, PH_V, PH_S, PH_Z} phase_t;

    typedef struct packed {
        logic                  a_sel;
        logic                  b_sel;
        logic                  b_transposed;
        logic [JOB_ADDR_W-1:0] a_base;
        logic [JOB_ADDR_W-1:0] b_base;
        logic [JOB_ADDR_W-1:0] res_base;
        logic [JOB_ADDR_W-1:0] sp_base;
        logic [JOB_DIM_W-1:0]  rows;
        logic [JOB_DIM_W-1:0]  inner;
        logic [JOB_DIM_W-1:0]  cols;
        logic                  sp_wr;
        logic                  sp_transpose;
    } attn_job_t;

    localparam int JOB_W = $bits(attn_job_t);

    // Dimension product reduced to the address width (wraps silently).
    function automatic logic [JOB_ADDR_W-1:0] mod_mul(input logic [JOB_DIM_W-1:0] a, input logic [JOB_DIM_W-1:0] b);
        return JOB_ADDR_W'((2*JOB_DIM_W)'(a) * (2*JOB_DIM_W)'(b));
    endfunction
endpackage

// File: rtl/attn_seq_ctrl_addr_gen.sv
// attn_addr_gen: combinational map from phase and running bases to a job descriptor
// Ports: phase (phase_t encoding); n/d/p dimensions; in_base and the running
// result (rb), scratchpad (sb) and weight (wb) bases; precomputed np/nn/dp
// products; job is the packed attn_job_t descriptor.
module attn_addr_gen
    import attn_seq_pkg::*;
(
    input  logic [2:0]            phase,
    input  logic [JOB_DIM_W-1:0]  n,
    input  logic [JOB_DIM_W-1:0]  d,
    input  logic [JOB_DIM_W-1:0]  p,
    input  logic [JOB_ADDR_W-1:0] in_base,
    input  logic [JOB_ADDR_W-1:0] rb,
    input  logic [JOB_ADDR_W-1:0] sb,
    input  logic [JOB_ADDR_W-1:0] wb,
    input  logic [JOB_ADDR_W-1:0] np,
    input  logic [JOB_ADDR_W-1:0] nn,
    input  logic [JOB_ADDR_W-1:0] dp,
    output logic [JOB_W-1:0]      job
);
    attn_job_t j;
    logic [JOB_ADDR_W-1:0] np2, np3, dp2;

    assign job = j;

    always_comb begin
        np2 = np + np;
        np3 = np2 + np;
        dp2 = dp + dp;
        j = '0;
        j.a_sel = SEL_A_INPUT;
        j.b_sel = SEL_B_WEIGHT;
        j.a_base = in_base;
        j.rows = n;
        j.inner = d;
        j.cols = p;
        case (phase)
            PH_Q: begin
                j.b_base = wb;
                j.res_base = rb;
            end
            PH_K: begin
                j.b_base = wb + dp;
                j.res_base = rb + np;
                j.sp_wr = 1'b1;
                j.sp_base = sb;
            end
            PH_V: begin
                j.b_base = wb + dp2;
                j.res_base = rb + np2;
                j.sp_wr = 1'b1;
                j.sp_transpose = 1'b1;
                j.sp_base = sb + np;
            end
            PH_S: begin
                j.a_sel = SEL_A_RESULT;
                j.a_base = rb;
                j.b_sel = SEL_B_SCRATCH;
                j.b_base = sb;
                j.b_transposed = 1'b1;
                j.inner = p;
                j.cols = n;
                j.res_base = rb + np3;
            end
            default: begin
                j.a_sel = SEL_A_RESULT;
                j.a_base = rb + np3;
                j.b_sel = SEL_B_SCRATCH;
                j.b_base = sb + np;
                j.b_transposed = 1'b1;
                j.inner = n;
                j.res_base = rb + np3 + nn;
            end
        endcase
    end
endmodule

// File: rtl/attn_seq_ctrl.sv
// attn_seq_ctrl: multi-head attention job sequencer driving a matrix-MAC engine
// Ports: clk, reset_n (async, active-low); start_valid/start_ready with cfg_*
// sampled on accept; job_valid/job_ready descriptor handshake with job_* fields;
// job_done completion pulse from the MAC; done/err end-of-sequence pulse;
// perf_cycles cycle counter, present only when ATTN_SEQ_PERF_EN is defined.
module attn_seq_ctrl
    import attn_seq_pkg::*;
#(
    parameter int ADDR_W    = JOB_ADDR_W,
    parameter int DIM_W     = JOB_DIM_W,
    parameter int NUM_HEADS = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [DIM_W-1:0]  cfg_n,
    input  logic [DIM_W-1:0]  cfg_d,
    input  logic [DIM_W-1:0]  cfg_p,
    input  logic [ADDR_W-1:0] cfg_in_base,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic [ADDR_W-1:0] cfg_res_base,
    input  logic [ADDR_W-1:0] cfg_sp_base,
    output logic              job_valid,
    input  logic              job_ready,
    output logic              job_a_sel,
    output logic              job_b_sel,
    output logic              job_b_transposed,
    output logic [ADDR_W-1:0] job_a_base,
    output logic [ADDR_W-1:0] job_b_base,
    output logic [ADDR_W-1:0] job_res_base,
    output logic [ADDR_W-1:0] job_sp_base,
    output logic [DIM_W-1:0]  job_rows,
    output logic [DIM_W-1:0]  job_inner,
    output logic [DIM_W-1:0]  job_cols,
    output logic              job_sp_wr,
    output logic              job_sp_transpose,
    input  logic              job_done,
    output logic              done,
    output logic              err,
    output logic [31:0]       perf_cycles
);
    state_t state, state_n;
    phase_t phase, phase_n;
    logic [2:0] head;
    logic [DIM_W-1:0] n_q, d_q, p_q;
    logic [ADDR_W-1:0] in_q, rb, sb, wb, np_q, nn_q, dp_q;
    logic [ADDR_W-1:0] rb_n, sb_n, wb_n, np_g, nn_g, dp_g;
    logic zero_cfg, last_ph, last_head, adv, load_job, err_q;
    logic [JOB_W-1:0] gen_job;
    attn_job_t job_q;

    // In PREP the products are not registered yet, so the first descriptor
    // uses them straight from the multipliers.
    always_comb begin
        np_g = state == PREP ? mod_mul(n_q, p_q) : np_q;
        nn_g = state == PREP ? mod_mul(n_q, n_q) : nn_q;
        dp_g = state == PREP ? mod_mul(d_q, p_q) : dp_q;
        zero_cfg = n_q == '0 || d_q == '0 || p_q == '0;
        last_ph = phase == PH_Z;
        last_head = head == 3'(NUM_HEADS - 1);
        adv = state == NEXT && last_ph;
        rb_n = adv ? rb + (np_q << 2) + nn_q : rb;
        sb_n = adv ? sb + (np_q << 1) : sb;
        wb_n = adv ? wb + (dp_q << 1) + dp_q : wb;
        phase_n = state != NEXT ? phase : last_ph ? PH_Q : phase_t'(phase + 3'd1);
        state_n = state;
        case (state)
            IDLE:    state_n = start_valid ? PREP : IDLE;
            PREP:    state_n = zero_cfg ? DONE : ISSUE;
            ISSUE:   state_n = job_ready ? WAIT : ISSUE;
            WAIT:    state_n = job_done ? NEXT : WAIT;
            NEXT:    state_n = last_ph && last_head ? DONE : ISSUE;
            default: state_n = IDLE;
        endcase
        load_job = state_n == ISSUE && (state == PREP || state == NEXT);
    end

    attn_addr_gen u_addr_gen (
        .phase   (phase_n),
        .n       (n_q),
        .d       (d_q),
        .p       (p_q),
        .in_base (in_q),
        .rb      (rb_n),
        .sb      (sb_n),
        .wb      (wb_n),
        .np      (np_g),
        .nn      (nn_g),
        .dp      (dp_g),
        .job     (gen_job)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            phase <= PH_Q;
            head <= '0;
            n_q <= '0;
            d_q <= '0;
            p_q <= '0;
            in_q <= '0;
            rb <= '0;
            sb <= '0;
            wb <= '0;
            np_q <= '0;
            nn_q <= '0;
            dp_q <= '0;
            err_q <= 1'b0;
            job_q <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start_valid) begin
                n_q <= cfg_n;
                d_q <= cfg_d;
                p_q <= cfg_p;
                in_q <= cfg_in_base;
                rb <= cfg_res_base;
                sb <= cfg_sp_base;
                wb <= cfg_w_base;
                phase <= PH_Q;
                head <= '0;
            end else begin
                rb <= rb_n;
                sb <= sb_n;
                wb <= wb_n;
                phase <= phase_n;
                head <= adv ? head + 3'd1 : head;
            end
            if (state == PREP) begin
                np_q <= np_g;
                nn_q <= nn_g;
                dp_q <= dp_g;
                err_q <= zero_cfg;
            end
            if (load_job)
                job_q <= attn_job_t'(gen_job);
        end
    end

    assign start_ready = state == IDLE;
    assign job_valid = state == ISSUE;
    assign done = state == DONE;
    assign err = done && err_q;
    assign job_a_sel = job_q.a_sel;
    assign job_b_sel = job_q.b_sel;
    assign job_b_transposed = job_q.b_transposed;
    assign job_a_base = job_q.a_base;
    assign job_b_base = job_q.b_base;
    assign job_res_base = job_q.res_base;
    assign job_sp_base = job_q.sp_base;
    assign job_rows = job_q.rows;
    assign job_inner = job_q.inner;
    assign job_cols = job_q.cols;
    assign job_sp_wr = job_q.sp_wr;
    assign job_sp_transpose = job_q.sp_transpose;

`ifdef ATTN_SEQ_PERF_EN
    logic [31:0] perf_q;

    // Counts every non-IDLE cycle including DONE, so the held value equals
    // the distance from the accept cycle to the done cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            perf_q <= '0;
        else if (state == IDLE)
            perf_q <= start_valid ? '0 : perf_q;
        else
            perf_q <= perf_q + 32'd1;
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif
endmodule

// File: tb/tb_attn_seq_ctrl.sv
// tb_attn_seq_ctrl: scoreboard bench for attn_seq_ctrl with a behavioural MAC
module tb_attn_seq_ctrl;
    localparam int AW = 12;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start_req = 1'b0;
    logic start_spur = 1'b0;
    logic start_valid;
    logic start_ready;
    logic [DW-1:0] cfg_n = '0, cfg_d = '0, cfg_p = '0;
    logic [AW-1:0] cfg_in_base = '0, cfg_w_base = '0, cfg_res_base = '0, cfg_sp_base = '0;
    logic job_valid;
    logic job_ready = 1'b1;
    logic job_a_sel, job_b_sel, job_b_transposed;
    logic [AW-1:0] job_a_base, job_b_base, job_res_base, job_sp_base;
    logic [DW-1:0] job_rows, job_inner, job_cols;
    logic job_sp_wr, job_sp_transpose;
    logic job_done = 1'b0;
    logic done, err;
    logic [31:0] perf_cycles;

    assign start_valid = start_req | start_spur;

    attn_seq_ctrl #(.ADDR_W(AW), .DIM_W(DW), .NUM_HEADS(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .cfg_n(cfg_n), .cfg_d(cfg_d), .cfg_p(cfg_p),
        .cfg_in_base(cfg_in_base), .cfg_w_base(cfg_w_base),
        .cfg_res_base(cfg_res_base), .cfg_sp_base(cfg_sp_base),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_a_sel(job_a_sel), .job_b_sel(job_b_sel), .job_b_transposed(job_b_transposed),
        .job_a_base(job_a_base), .job_b_base(job_b_base),
        .job_res_base(job_res_base), .job_sp_base(job_sp_base),
        .job_rows(job_rows), .job_inner(job_inner), .job_cols(job_cols),
        .job_sp_wr(job_sp_wr), .job_sp_transpose(job_sp_transpose),
        .job_done(job_done), .done(done), .err(err), .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic a_sel, b_sel, bt;
        logic [AW-1:0] a, b, r, sp;
        logic [DW-1:0] rows, inner, cols;
        logic spw, spt;
    } job_t;

    job_t exp_q[$];
    logic exp_err_q[$];
    job_t cur, last;
    int total = 0, bad = 0;
    int cyc = 0, kick_cyc = 0, start_cyc = 0, done_cyc = 0;
    int acc_total = 0, seq_base = 0, stall_seen = 0;
    int stall_len = 0;
    logic spur_en = 1'b0, start_in_wait = 1'b0;
    logic last_stall = 1'b0, prev_valid = 1'b0;

    assign cur = {job_a_sel, job_b_sel, job_b_transposed, job_a_base, job_b_base,
                  job_res_base, job_sp_base, job_rows, job_inner, job_cols,
                  job_sp_wr, job_sp_transpose};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: scoreboard for accepted descriptors and done pulses, plus
    // handshake timing and stall stability.
    initial forever begin
        @(negedge clk);
        if (job_valid && !prev_valid)
            chk("job_valid latency", cyc, kick_cyc + 2);
        if (job_valid && last_stall)
            chk("stalled descriptor stable", cur, last);
        if (job_valid && !job_ready)
            stall_seen++;
        if (job_valid && job_ready) begin
            chk("job expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0)
                chk($sformatf("job %0d", acc_total - seq_base), cur, exp_q.pop_front());
            acc_total++;
        end
        if (done) begin
            chk("done latency", cyc, kick_cyc + 2);
            chk("done expected", exp_err_q.size() != 0, 1);
            if (exp_err_q.size() != 0)
                chk("done err", err, exp_err_q.pop_front());
        end
        last_stall = job_valid && !job_ready;
        last = cur;
        prev_valid = job_valid;
    end

    // MAC model: job_done 5 cycles after accept, optional ready stall with a
    // spurious job_done inside it, optional stray start pulse while waiting.
    initial begin
        int seen, cnt, stalled;
        seen = 0;
        cnt = 0;
        stalled = 0;
        forever begin
            @(posedge clk);
            #1;
            job_done = 1'b0;
            start_spur = 1'b0;
            job_ready = 1'b1;
            if (!reset_n) begin
                cnt = 0;
                seen = acc_total;
            end else if (acc_total != seen) begin
                seen = acc_total;
                cnt = 5;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 3 && start_in_wait)
                    start_spur = 1'b1;
                if (cnt == 0) begin
                    job_done = 1'b1;
                    kick_cyc = cyc;
                end
            end
            if (job_valid && (acc_total - seq_base) % 5 == 3 && stalled < stall_len) begin
                job_ready = 1'b0;
                stalled++;
                if (spur_en && stalled == 3)
                    job_done = 1'b1;
            end
        end
    end

    task automatic pj(input logic as, input logic bs, input logic bt,
                      input int a, input int b, input int r, input int sp,
                      input int rows, input int inner, input int cols,
                      input logic spw, input logic spt);
        job_t j;
        j.a_sel = as; j.b_sel = bs; j.bt = bt;
        j.a = AW'(a); j.b = AW'(b); j.r = AW'(r); j.sp = AW'(sp);
        j.rows = DW'(rows); j.inner = DW'(inner); j.cols = DW'(cols);
        j.spw = spw; j.spt = spt;
        exp_q.push_back(j);
    endtask

    // N=4 D=8 P=2, all bases 0: NP=8 NN=16 DP=16
    task automatic push_a();
        pj(0,0,0,  0,  0,  0,  0, 4,8,2, 0,0);
        pj(0,0,0,  0, 16,  8,  0, 4,8,2, 1,0);
        pj(0,0,0,  0, 32, 16,  8, 4,8,2, 1,1);
        pj(1,1,1,  0,  0, 24,  0, 4,2,4, 0,0);
        pj(1,1,1, 24,  8, 40,  0, 4,4,2, 0,0);
        pj(0,0,0,  0, 48, 48,  0, 4,8,2, 0,0);
        pj(0,0,0,  0, 64, 56, 16, 4,8,2, 1,0);
        pj(0,0,0,  0, 80, 64, 24, 4,8,2, 1,1);
        pj(1,1,1, 48, 16, 72,  0, 4,2,4, 0,0);
        pj(1,1,1, 72, 24, 88,  0, 4,4,2, 0,0);
        exp_err_q.push_back(1'b0);
    endtask

    // N=3 D=5 P=2, in=100 w=4090 res=4080 sp=4095: NP=6 NN=9 DP=10, wraps mod 4096
    task automatic push_b();
        pj(0,0,0,  100, 4090, 4080,    0, 3,5,2, 0,0);
        pj(0,0,0,  100,    4, 4086, 4095, 3,5,2, 1,0);
        pj(0,0,0,  100,   14, 4092,    5, 3,5,2, 1,1);
        pj(1,1,1, 4080, 4095,    2,    0, 3,2,3, 0,0);
        pj(1,1,1,    2,    5,   11,    0, 3,3,2, 0,0);
        pj(0,0,0,  100,   24,   17,    0, 3,5,2, 0,0);
        pj(0,0,0,  100,   34,   23,   11, 3,5,2, 1,0);
        pj(0,0,0,  100,   44,   29,   17, 3,5,2, 1,1);
        pj(1,1,1,   17,   11,   35,    0, 3,2,3, 0,0);
        pj(1,1,1,   35,   17,   44,    0, 3,3,2, 0,0);
        exp_err_q.push_back(1'b0);
    endtask

    task automatic run_start(input int n, input int d, input int p,
                             input int ib, input int wb, input int rb, input int sb);
        @(posedge clk);
        #1;
        cfg_n = DW'(n); cfg_d = DW'(d); cfg_p = DW'(p);
        cfg_in_base = AW'(ib); cfg_w_base = AW'(wb);
        cfg_res_base = AW'(rb); cfg_sp_base = AW'(sb);
        start_req = 1'b1;
        seq_base = acc_total;
        start_cyc = cyc;
        kick_cyc = cyc;
        @(posedge clk);
        #1;
        start_req = 1'b0;
        cfg_n = '1; cfg_d = '1; cfg_p = '1;
        cfg_in_base = '1; cfg_w_base = '1; cfg_res_base = '1; cfg_sp_base = '1;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done within budget", k < 2000, 1);
        done_cyc = cyc;
        @(negedge clk);
        chk("start_ready after done", start_ready, 1);
        chk("scoreboard drained", exp_q.size(), 0);
`ifdef ATTN_SEQ_PERF_EN
        chk("perf_cycles", perf_cycles, done_cyc - start_cyc);
`else
        chk("perf_cycles tied", perf_cycles, 0);
`endif
    endtask

    task automatic chk_reset_vals();
        chk("reset start_ready", start_ready, 1);
        chk("reset job_valid", job_valid, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        chk("reset descriptor", cur, 0);
        chk("reset perf_cycles", perf_cycles, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals();
        reset_n = 1'b1;

        push_a();
        run_start(4, 8, 2, 0, 0, 0, 0);
        wait_done();

        start_in_wait = 1'b1;
        push_b();
        run_start(3, 5, 2, 100, 4090, 4080, 4095);
        wait_done();
        start_in_wait = 1'b0;

        exp_err_q.push_back(1'b1);
        run_start(4, 8, 0, 0, 0, 0, 0);
        wait_done();
        exp_err_q.push_back(1'b1);
        run_start(0, 8, 2, 0, 0, 0, 0);
        wait_done();

        stall_len = 7;
        spur_en = 1'b1;
        push_a();
        run_start(4, 8, 2, 0, 0, 0, 0);
        wait_done();
        chk("stall cycles on S", stall_seen, 7);
        spur_en = 1'b0;

        push_a();
        run_start(4, 8, 2, 0, 0, 0, 0);
        for (k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (acc_total - seq_base == 3) break;
        end
        chk("V accepted within budget", k < 200, 1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset_vals();
        exp_q.delete();
        exp_err_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        push_a();
        run_start(4, 8, 2, 0, 0, 0, 0);
        wait_done();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
